dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Word-organised data-memory responder for the MEM stage of the five-stage pipeline.
//  Accepts one load/store request at a time over a valid/ready request channel.
//  Returns the result over a valid/ready response channel after a fixed, parameterised
//  number of wait states, so pipeline stall logic can be exercised.
// PARAMETERS
//  DEPTH_WORDS  1024           number of 32-bit words; power of two
//  WAIT_CYCLES  2              wait states between accept and response; 0..15
//  ADDR_BASE    32'h0000_0000  byte address mapped to word 0
// PORTS
//  clk        in   1   clock; all state updates on the rising edge
//  rst        in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   responder can accept a request
//  req_we     in   1   1 = store, 0 = load
//  req_addr   in   32  byte address; bits [1:0] ignored
//  req_wdata  in   32  store data
//  req_wstrb  in   4   store byte enables; bit i writes byte i (wdata[8i+7:8i])
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   requester accepts response
//  rsp_rdata  out  32  load data; 0 for stores
//  rsp_err    out  1   access fault (see CONFIGURATION); constant 0 without macro
// BEHAVIOUR
//  Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE, counter=0.
//  Memory array is not reset.
//  req_ready is registered: it rises on the first edge after rst deasserts. It is 1 only in IDLE.
//  FSM states:
//   - IDLE: on req_valid&&req_ready, capture we/addr/wdata/wstrb and load counter=WAIT_CYCLES.
//     Go to WAIT if WAIT_CYCLES>0, else go to EXEC.
//   - WAIT: decrement counter each cycle; at counter==1, go to EXEC.
//   - EXEC: one cycle.
//     Store: write bytes selected by wstrb at the word index; rdata=0.
//     Load: rdata = mem[index].
//     Set rsp_valid=1 and go to RESP.
//   - RESP: hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready.
//     On rsp_valid&&rsp_ready, clear rsp_valid and return to IDLE; req_ready=1 on the next cycle.
//  Latency: request accepted at edge N gives rsp_valid high after edge N+WAIT_CYCLES+1.
//  If rsp_ready is already high, the response completes at edge N+WAIT_CYCLES+2.
//  Throughput: at most one request per WAIT_CYCLES+3 cycles.
//  Index = ((req_addr - ADDR_BASE) >> 2) mod DEPTH_WORDS.
//  Subtraction wraps modulo 2^32, so out-of-window addresses alias without the macro.
//  wstrb=4'b0000 on a store: no byte written; a normal response is still returned.
//  Load after store to the same word returns the new data; the store commits in EXEC.
//  rst asserted mid-operation: return immediately to IDLE and drop any outstanding response.
//  A store that has not yet reached EXEC is discarded. A store completed in EXEC remains in memory.
//  Requester inputs are ignored outside IDLE. Captured fields do not follow input changes.
// CONFIGURATION
//  DMEM_RANGE_CHECK_EN defined:
//   - An address whose byte offset from ADDR_BASE is >= DEPTH_WORDS*4 faults.
//   - A fault on a store writes nothing; a fault on a load returns rdata=0.
//   - rsp_err=1 for that response.
//   - Timing is identical to a normal access.
//  Macro not defined: no range check; addresses alias as above; rsp_err is tied to 0.
// TESTING
//  1. Reset release: rst 1->0 -> req_ready=0 in first cycle, 1 after next edge; rsp_valid=0.
//  2. Store then load, WAIT_CYCLES=2:
//     store addr 0x10, data 0xDEADBEEF, wstrb 4'hF -> rsp_valid 3 edges after accept.
//     Load 0x10 -> rdata=0xDEADBEEF.
//  3. Byte strobes:
//     store 0xAABBCCDD to 0x20 with wstrb 4'hF, then 0x11223344 with wstrb 4'b0101.
//     Load 0x20 -> rdata=0xAA22CC44.
//  4. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rdata stable, req_ready=0.
//     Raise rsp_ready -> handshake completes, then req_ready=1.
//  5. Mid-op reset: assert rst in WAIT of a store 0x55 to 0x30 -> outputs return to reset values.
//     Later load of 0x30 -> old contents unchanged.
//  6. DEPTH_WORDS=1024, load 0x1000:
//     with DMEM_RANGE_CHECK_EN -> rsp_err=1, rdata=0.
//     Without the macro -> aliases word 0 and returns its data, rsp_err=0.

Source files
------------

// File: rtl/dmem_responder_if.sv
// Request/response bus between the MEM stage and the data-memory responder.
// master: pipeline-side requester; slave: dmem_responder.
interface dmem_responder_if;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = DATA_W / 8;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic [STRB_W-1:0] req_wstrb;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_wstrb, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with a fixed number of wait states
// between request accept and response, one request in flight at a time.
// Optional feature: define DMEM_RANGE_CHECK_EN to fault accesses whose byte
// offset from ADDR_BASE falls outside the array (rsp_err=1, no write, rdata=0).
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EXEC, S_RESP} state_t;

   state_t              state, state_next;
   logic [CNT_W-1:0]    count, count_next;
   logic                we_q, we_next;
   logic [IDX_W-1:0]    idx_q, idx_next;
   logic [DATA_W-1:0]   wdata_q, wdata_next;
   logic [STRB_W-1:0]   wstrb_q, wstrb_next;
   logic                fault_q, fault_next;
   logic                ready_q, ready_next;
   logic                valid_q, valid_next;
   logic [DATA_W-1:0]   rdata_q, rdata_next;
   logic                err_q, err_next;

   logic [DATA_W-1:0]   mem [DEPTH_WORDS];

   logic [31:0]         offset_c;
   logic [IDX_W-1:0]    idx_c;
   logic                fault_c;
   logic                unused_c;

   // Byte offset into the window; subtraction wraps so out-of-window addresses alias.
   assign offset_c = bus.req_addr - ADDR_BASE;
   assign idx_c    = offset_c[IDX_W+1:2];
   assign unused_c = ^{offset_c[1:0], offset_c[31:IDX_W+2]};

`ifdef DMEM_RANGE_CHECK_EN
   // Any offset bit above the array span marks the access as out of range.
   assign fault_c = (offset_c >> (IDX_W + 2)) != 32'd0;
`else
   assign fault_c = 1'b0;
`endif

   // State, capture and registered-output flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         count   <= '0;
         we_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         fault_q <= 1'b0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_next;
         count   <= count_next;
         we_q    <= we_next;
         idx_q   <= idx_next;
         wdata_q <= wdata_next;
         wstrb_q <= wstrb_next;
         fault_q <= fault_next;
         ready_q <= ready_next;
         valid_q <= valid_next;
         rdata_q <= rdata_next;
         err_q   <= err_next;
      end
   end

   // Next-state and next-output logic; requester inputs only matter in IDLE.
   always_comb begin
      state_next = state;
      count_next = count;
      we_next    = we_q;
      idx_next   = idx_q;
      wdata_next = wdata_q;
      wstrb_next = wstrb_q;
      fault_next = fault_q;
      valid_next = valid_q;
      rdata_next = rdata_q;
      err_next   = err_q;
      ready_next = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.req_valid && ready_q) begin
               we_next    = bus.req_we;
               idx_next   = idx_c;
               wdata_next = bus.req_wdata;
               wstrb_next = bus.req_wstrb;
               fault_next = fault_c;
               count_next = CNT_W'(WAIT_CYCLES);
               state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_EXEC;
            end
         end
         S_WAIT: begin
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            valid_next = 1'b1;
            err_next   = fault_q;
            rdata_next = (we_q || fault_q) ? '0 : mem[idx_q];
            state_next = S_RESP;
         end
         S_RESP: begin
            if (bus.rsp_ready) begin
               valid_next = 1'b0;
               state_next = S_IDLE;
            end
         end
         default: state_next = S_IDLE;
      endcase

      ready_next = (state_next == S_IDLE);
   end

   // Store commit in EXEC; the array itself is never reset.
   always_ff @(posedge clk) begin
      if (state == S_EXEC && we_q && !fault_q) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) begin
               mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
            end
         end
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.rsp_valid = valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_err   = err_q;
endmodule
